// File: rtl/resonator_dds_pkg.sv
// Shared definitions for the resonator DDS complex multiplier: mode bit
// indices, minimum pipeline depth and the saturate/wrap helpers.
package resonator_dds_pkg;

   localparam int MODE_ROUND = 0;
   localparam int MODE_SAT   = 1;

   function automatic int min_num_stage();
      return 4;
   endfunction

   // Clamp to the signed range of 'width' bits when en=1; otherwise pass through.
   // The caller keeps the low 'width' bits, which is the wrap behaviour.
   function automatic logic signed [63:0] sat_wrap(input logic signed [63:0] value,
                                                   input int width,
                                                   input logic en);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (en && (value > hi)) begin
         return hi;
      end else if (en && (value < lo)) begin
         return lo;
      end else begin
         return value;
      end
   endfunction

   function automatic logic out_of_range(input logic signed [63:0] value,
                                         input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      return (value > hi) || (value < lo);
   endfunction

endpackage

// File: rtl/resonator_dds_cmul_lane.sv
// One complex lane: products (stage 2), sum/difference (stage 3) and
// round/shift/saturate with overflow detection (stage 4).
module resonator_dds_cmul_lane
   import resonator_dds_pkg::*;
#(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               ce,
   input  logic [2*A_W-1:0]   a,
   input  logic [2*B_W-1:0]   b,
   input  logic [1:0]         mode,
   output logic [2*OUT_W-1:0] dout,
   output logic               ovf
);
   localparam int PW = A_W + B_W;
   localparam int SW = PW + 1;
   // One spare bit so adding the rounding constant can never wrap.
   localparam int RW = SW + 1;
   localparam logic signed [RW-1:0] RND_C = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);

   logic signed [PW-1:0]  p_rr_d, p_ii_d, p_ri_d, p_ir_d;
   logic signed [PW-1:0]  p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic signed [SW-1:0]  re_d, im_d, re_q, im_q;
   logic signed [RW-1:0]  rnd_s, re_sh_s, im_sh_s;
   logic [OUT_W-1:0]      re_o_s, im_o_s;
   logic [2*OUT_W-1:0]    dout_d, dout_q;
   logic                  ovf_d, ovf_q;

   always_comb begin
      p_rr_d = PW'($signed(a[A_W-1:0]))     * PW'($signed(b[B_W-1:0]));
      p_ii_d = PW'($signed(a[2*A_W-1:A_W])) * PW'($signed(b[2*B_W-1:B_W]));
      p_ri_d = PW'($signed(a[A_W-1:0]))     * PW'($signed(b[2*B_W-1:B_W]));
      p_ir_d = PW'($signed(a[2*A_W-1:A_W])) * PW'($signed(b[B_W-1:0]));

      re_d = SW'(p_rr_q) - SW'(p_ii_q);
      im_d = SW'(p_ri_q) + SW'(p_ir_q);

      if (mode[MODE_ROUND]) begin
         rnd_s = RND_C;
      end else begin
         rnd_s = '0;
      end
      re_sh_s = (RW'(re_q) + rnd_s) >>> SHIFT;
      im_sh_s = (RW'(im_q) + rnd_s) >>> SHIFT;

      re_o_s = OUT_W'(sat_wrap(64'(re_sh_s), OUT_W, mode[MODE_SAT]));
      im_o_s = OUT_W'(sat_wrap(64'(im_sh_s), OUT_W, mode[MODE_SAT]));
      dout_d = {im_o_s, re_o_s};
      ovf_d  = out_of_range(64'(re_sh_s), OUT_W) | out_of_range(64'(im_sh_s), OUT_W);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_rr_q <= '0;
         p_ii_q <= '0;
         p_ri_q <= '0;
         p_ir_q <= '0;
         re_q   <= '0;
         im_q   <= '0;
         dout_q <= '0;
         ovf_q  <= 1'b0;
      end else if (ce) begin
         p_rr_q <= p_rr_d;
         p_ii_q <= p_ii_d;
         p_ri_q <= p_ri_d;
         p_ir_q <= p_ir_d;
         re_q   <= re_d;
         im_q   <= im_d;
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign dout = dout_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/resonator_dds_cmul_pipe.sv
// Multi-lane pipelined signed complex multiplier with per-sample round and
// saturate modes, a data-aligned valid pipe and overflow reporting.
module resonator_dds_cmul_pipe
   import resonator_dds_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int A_W       = 16,
   parameter int B_W       = 16,
   parameter int OUT_W     = 16,
   parameter int SHIFT     = 15,
   parameter int NUM_STAGE = 4
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ce,
   input  logic                     in_valid,
   input  logic [LANES*2*A_W-1:0]   din0,
   input  logic [LANES*2*B_W-1:0]   din1,
   input  logic [1:0]               mode,
   output logic                     out_valid,
   output logic [LANES*2*OUT_W-1:0] dout,
   output logic [LANES-1:0]         ovf,
   output logic                     ovf_sticky
);
   localparam int EXTRA = NUM_STAGE - min_num_stage();
   localparam int DW    = LANES * 2 * OUT_W;

   if ((NUM_STAGE < min_num_stage()) || (SHIFT < 1) || (SHIFT > A_W + B_W) ||
       (A_W + B_W + 2 > 64)) begin : g_bad_param
      $error("resonator_dds_cmul_pipe: illegal NUM_STAGE, SHIFT or operand widths");
   end

   logic [LANES*2*A_W-1:0] din0_d, din0_q;
   logic [LANES*2*B_W-1:0] din1_d, din1_q;
   logic [1:0]             mode1_d, mode1_q, mode2_d, mode2_q, mode3_d, mode3_q;
   logic [NUM_STAGE:1]     vld_d, vld_q;
   logic                   sticky_d, sticky_q;
   logic [DW-1:0]          s4_dout_s, dout_s;
   logic [LANES-1:0]       s4_ovf_s, ovf_s, ovf_qual_s;

   // mode travels alongside the data so stage 4 sees the mode of its own sample.
   always_comb begin
      din0_d   = din0;
      din1_d   = din1;
      mode1_d  = mode;
      mode2_d  = mode1_q;
      mode3_d  = mode2_q;
      vld_d    = {vld_q[NUM_STAGE-1:1], in_valid};
      sticky_d = sticky_q | (vld_q[NUM_STAGE] & (|ovf_qual_s));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         din0_q   <= '0;
         din1_q   <= '0;
         mode1_q  <= 2'b00;
         mode2_q  <= 2'b00;
         mode3_q  <= 2'b00;
         vld_q    <= '0;
         sticky_q <= 1'b0;
      end else if (ce) begin
         din0_q   <= din0_d;
         din1_q   <= din1_d;
         mode1_q  <= mode1_d;
         mode2_q  <= mode2_d;
         mode3_q  <= mode3_d;
         vld_q    <= vld_d;
         sticky_q <= sticky_d;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      resonator_dds_cmul_lane #(
         .A_W   (A_W),
         .B_W   (B_W),
         .OUT_W (OUT_W),
         .SHIFT (SHIFT)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .ce    (ce),
         .a     (din0_q[l*2*A_W +: 2*A_W]),
         .b     (din1_q[l*2*B_W +: 2*B_W]),
         .mode  (mode3_q),
         .dout  (s4_dout_s[l*2*OUT_W +: 2*OUT_W]),
         .ovf   (s4_ovf_s[l])
      );
   end

   if (EXTRA > 0) begin : g_dly
      logic [EXTRA-1:0][DW+LANES-1:0] dly_d, dly_q;

      always_comb begin
         dly_d[0] = {s4_ovf_s, s4_dout_s};
         for (int i = 1; i < EXTRA; i++) begin
            dly_d[i] = dly_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            dly_q <= '0;
         end else if (ce) begin
            dly_q <= dly_d;
         end
      end

      assign {ovf_s, dout_s} = dly_q[EXTRA-1];
   end else begin : g_nodly
      assign {ovf_s, dout_s} = {s4_ovf_s, s4_dout_s};
   end

   assign ovf_qual_s = ovf_s & {LANES{vld_q[NUM_STAGE]}};
   assign out_valid  = vld_q[NUM_STAGE];
   assign dout       = dout_s;
   assign ovf        = ovf_qual_s;
   assign ovf_sticky = sticky_q;

endmodule
